cu_read_command_arbiter: RTL and testbench

//  Round-robin arbiter that shares the CU's single read-command channel among NUM_REQ

---
 rtl/cu_read_command_arbiter_pkg.sv | 14 +
 rtl/cu_read_command_arbiter_rr_priority_select.sv | 24 ++
 rtl/cu_read_command_arbiter.sv | 105 ++++++++++
 tb/tb_cu_read_command_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cu_read_command_arbiter_pkg.sv
// cu_read_command_arbiter_pkg: shared types and constants for the CU read-command arbiter
package cu_read_command_arbiter_pkg;
  localparam int CU_READ_ARB_NUM_REQ = 3;
  localparam int CU_READ_ARB_MAX_OUTSTANDING = 16;
  typedef enum logic [1:0] {IDLE, GRANT, CAPTURE, DRAIN} ArbiterState;
  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [7:0]  size;
  } CommandBufferLine;
  typedef struct packed {
    logic alfull;
  } BufferStatus;
endpackage

// File: rtl/cu_read_command_arbiter_rr_priority_select.sv
// rr_priority_select: picks the first eligible requester at or after the round-robin pointer
module rr_priority_select #(
  parameter int NUM_REQ = 3,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IW-1:0]      o_index,
  output logic               o_any
);
  // Scan from farthest to nearest so the nearest eligible slot is the one left standing
  always_comb begin
    o_onehot = '0;
    o_index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (|(i_eligible & (NUM_REQ'(1) << ((int'(i_ptr) + k) % NUM_REQ)))) begin
        o_onehot = NUM_REQ'(1) << ((int'(i_ptr) + k) % NUM_REQ);
        o_index = IW'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end
  assign o_any = |i_eligible;
endmodule

// File: rtl/cu_read_command_arbiter.sv
// cu_read_command_arbiter: round-robin sharing of the CU read-command channel among requester FIFOs
module cu_read_command_arbiter
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CU_READ_ARB_NUM_REQ,
  parameter int MAX_OUTSTANDING = CU_READ_ARB_MAX_OUTSTANDING,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             i_clock,
  input  logic                             i_rstn,
  input  logic                             i_enabled,
  input  logic [NUM_REQ-1:0]               i_request,
  input  CommandBufferLine [NUM_REQ-1:0]   i_command,
  input  logic [NUM_REQ-1:0]               i_response_done,
  input  BufferStatus                      i_read_buffer_status,
  output logic [NUM_REQ-1:0]               o_grant,
  output CommandBufferLine                 o_read_command,
  output logic [NUM_REQ-1:0][CW-1:0]       o_outstanding,
  output logic                             o_arbiter_idle
);
  ArbiterState r_state;
  logic r_en;
  logic [IW-1:0] r_ptr, r_idx, w_next_ptr, w_sel_ptr, w_sel_idx;
  logic [NUM_REQ-1:0] r_grant, w_eligible, w_onehot;
  logic w_any, w_capture, w_cap_valid;
  CommandBufferLine r_cmd, w_cap_cmd;
  logic [NUM_REQ-1:0][CW-1:0] w_cnt;

  assign w_capture = (r_state == CAPTURE) || (r_state == DRAIN);
  assign w_cap_cmd = i_command[r_idx];
  assign w_cap_valid = w_capture && w_cap_cmd.valid;
  assign w_next_ptr = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + IW'(1);
  assign w_sel_ptr = (r_state == CAPTURE) ? w_next_ptr : r_ptr;

  // A capture landing this cycle already counts against its requester's credit
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_eligible[i] = i_request[i] && !i_read_buffer_status.alfull &&
        (int'(w_cnt[i]) + int'(w_cap_valid && r_idx == IW'(i)) < MAX_OUTSTANDING);
  end

  rr_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
    .i_eligible(w_eligible),
    .i_ptr(w_sel_ptr),
    .o_onehot(w_onehot),
    .o_index(w_sel_idx),
    .o_any(w_any)
  );

  // Grant/capture sequencer; grant and command outputs are registered and default low
  always_ff @(posedge i_clock or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_en <= 1'b0;
      r_ptr <= '0;
      r_idx <= '0;
      r_grant <= '0;
      r_cmd <= '0;
    end else begin
      r_en <= i_enabled;
      r_grant <= '0;
      r_cmd <= '0;
      case (r_state)
        IDLE: if (r_en && w_any) begin
          r_state <= GRANT;
          r_grant <= w_onehot;
          r_idx <= w_sel_idx;
        end
        GRANT: r_state <= r_en ? CAPTURE : DRAIN;
        default: begin
          r_cmd <= w_cap_cmd.valid ? w_cap_cmd : '0;
          r_ptr <= w_next_ptr;
          if (r_state == CAPTURE && r_en && w_any) begin
            r_state <= GRANT;
            r_grant <= w_onehot;
            r_idx <= w_sel_idx;
          end else r_state <= IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_credit
    logic [CW-1:0] r_cnt;
    logic w_inc, w_dec;
    assign w_inc = w_cap_valid && r_idx == IW'(i);
    assign w_dec = i_response_done[i];
    // Capture consumes a credit, completion returns one; both together cancel, empty saturates
    always_ff @(posedge i_clock or negedge i_rstn) begin
      if (!i_rstn) r_cnt <= '0;
      else if (w_inc && !w_dec) r_cnt <= r_cnt + CW'(1);
      else if (w_dec && !w_inc && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
    assign w_cnt[i] = r_cnt;
    a_no_credit_underflow: assert property (@(posedge i_clock) disable iff (!i_rstn)
      !(w_dec && !w_inc && r_cnt == '0));
  end

  assign o_grant = r_grant;
  assign o_read_command = r_cmd;
  assign o_outstanding = w_cnt;
  assign o_arbiter_idle = (r_state == IDLE) && ~|w_cnt && !r_cmd.valid;
endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// tb_cu_read_command_arbiter: randomized check against a latency/credit/round-robin reference model
module tb_cu_read_command_arbiter;
  import cu_read_command_arbiter_pkg::*;
  localparam int N = 3, MO = 4, CW = $clog2(MO + 1);
  logic clk = 0, rstn = 0, en = 0;
  logic [N-1:0] req = '0, resp = '0;
  CommandBufferLine [N-1:0] cmd_in = '0;
  BufferStatus status = '0;
  logic [N-1:0] grant;
  CommandBufferLine rd_cmd;
  logic [N-1:0][CW-1:0] outstanding;
  logic idle;
  int checks = 0, errors = 0;
  CommandBufferLine q[N][$];
  int cnt[N];
  int ptr, e, g_edge, g_idx, pop_idx;
  logic m_en, en_g1, pop_now, only0, rst_done;
  int p_push, p_resp;
  logic [N-1:0] exp_grant;
  CommandBufferLine exp_cmd;
  logic exp_idle;

  always #5 clk = ~clk;

  cu_read_command_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MO)) dut (
    .i_clock(clk),
    .i_rstn(rstn),
    .i_enabled(en),
    .i_request(req),
    .i_command(cmd_in),
    .i_response_done(resp),
    .i_read_buffer_status(status),
    .o_grant(grant),
    .o_read_command(rd_cmd),
    .o_outstanding(outstanding),
    .o_arbiter_idle(idle)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic CommandBufferLine rand_cmd(input bit v);
    CommandBufferLine c;
    c.valid = v;
    c.address = $urandom;
    c.size = 8'($urandom);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      q[i].delete();
    end
    ptr = 0;
    g_edge = e - 100;
    g_idx = 0;
    m_en = 0;
    en_g1 = 0;
    pop_now = 0;
  endtask

  // One clock edge of the spec: grant one cycle after decision, capture two cycles after,
  // rr from last grant + 1, credits counted from captured valid commands and responses
  task automatic model_step();
    CommandBufferLine cap;
    logic [N-1:0] elig;
    int old_g = g_edge;
    int cap_idx = g_idx;
    bit decided = 0;
    bit inc;
    bit all_zero = 1;
    int pick = 0;
    e++;
    cap = (e == old_g + 2) ? cmd_in[cap_idx] : '0;
    if (!cap.valid) cap = '0;
    if (e == old_g + 1) en_g1 = m_en;
    for (int i = 0; i < N; i++)
      elig[i] = req[i] && !status.alfull && (cnt[i] + ((cap.valid && cap_idx == i) ? 1 : 0) < MO);
    if (m_en && ((e == old_g + 2 && en_g1) || e >= old_g + 3))
      for (int k = 0; k < N; k++)
        if (!decided && elig[(ptr + k) % N]) begin
          decided = 1;
          pick = (ptr + k) % N;
        end
    if (decided) begin
      g_edge = e;
      g_idx = pick;
      ptr = (pick + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      inc = cap.valid && cap_idx == i;
      if (inc && !resp[i]) cnt[i]++;
      else if (resp[i] && !inc && cnt[i] > 0) cnt[i]--;
      if (cnt[i] != 0) all_zero = 0;
    end
    pop_now = (e == old_g + 1);
    pop_idx = cap_idx;
    exp_grant = decided ? N'(1) << pick : '0;
    exp_cmd = cap;
    exp_idle = !decided && (e != old_g + 1) && all_zero && !cap.valid;
    m_en = en;
  endtask

  initial begin
    e = 0;
    rst_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant", grant, '0);
    check("reset_read_cmd", rd_cmd, '0);
    check("reset_outstanding", outstanding, '0);
    check("reset_idle", idle, 1'b1);
    rstn = 1;
    for (int c = 0; c < 2600; c++) begin
      if (c < 300) begin
        only0 = 1; p_push = 60; p_resp = 40; status.alfull = 0; en = 1;
      end else if (c < 900) begin
        only0 = 0; p_push = 80; p_resp = 10;
      end else if (c < 1400) begin
        p_push = 50; p_resp = 30;
        if (c % 10 == 0) status.alfull = 1'($urandom_range(1));
        if ($urandom_range(19) == 0) en = ~en;
      end else if (c < 2400) begin
        p_push = 40; p_resp = 50;
        status.alfull = ($urandom_range(7) == 0);
        if ($urandom_range(29) == 0) en = ~en;
      end else begin
        p_push = 0; p_resp = 70; status.alfull = 0; en = 1;
      end
      for (int i = 0; i < N; i++) begin
        if (pop_now && i == pop_idx) cmd_in[i] = (q[i].size() != 0) ? q[i].pop_front() : '0;
        else cmd_in[i] = rand_cmd(1'($urandom_range(1)));
        if ((i == 0 || !only0) && q[i].size() < 8 && $urandom_range(99) < p_push)
          q[i].push_back(rand_cmd($urandom_range(15) != 0));
        req[i] = q[i].size() != 0;
        resp[i] = cnt[i] > 0 && $urandom_range(99) < p_resp;
      end
      @(posedge clk);
      model_step();
      #1;
      check("grant", grant, exp_grant);
      check("read_cmd", rd_cmd, exp_cmd);
      for (int i = 0; i < N; i++) check($sformatf("outstanding%0d", i), outstanding[i], cnt[i]);
      check("idle", idle, exp_idle);
      if (!rst_done && c >= 1700 && exp_cmd.valid) begin
        rst_done = 1;
        rstn = 0;
        #1;
        check("midrst_read_cmd", rd_cmd, '0);
        check("midrst_grant", grant, '0);
        check("midrst_outstanding", outstanding, '0);
        check("midrst_idle", idle, 1'b1);
        req = '0;
        resp = '0;
        @(posedge clk);
        #1 rstn = 1;
        e++;
        model_reset();
      end
    end
    check("final_idle", idle, 1'b1);
    check("mid_reset_taken", rst_done, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
